i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
Parametrised I2C target with a register bank, for the next-generation dice/display peripherals. It generalises the fixed-address, fixed-size I2C slave to N registers, with a configurable read-only status region, glitch filtering and subaddress auto-increment with wrap. It sits between the uio SDA/SCL pads and the display, PWM and dice configuration logic, and supplies RW register contents as a flat vector.

Parameters:
I2C_ADDR, 7'h70, 7-bit target address (write byte 0xE0, read byte 0xE1)
NUM_REGS, 16, total registers, 2..128
RO_FIRST, 12, index of first read-only register; registers RO_FIRST..NUM_REGS-1 read ro_in; RO_FIRST=NUM_REGS means none
FILT_LEN, 3, glitch-filter length in clk cycles, 1..7

Ports:
clk  in  1  system clock; must be at least 16x the SCL rate
rst_n  in  1  asynchronous active-low reset
sda_in  in  1  SDA pad input
scl_in  in  1  SCL pad input
sda_oe  out  1  1 = pull SDA low; pad output is tied 0
rw_regs  out  RO_FIRST*8  RW register contents; reg k is at [8k+7:8k]
ro_in  in  (NUM_REGS-RO_FIRST)*8  status bytes; sampled at read-load time
wr_stb  out  1  one-cycle pulse after each accepted RW register write
wr_idx  out  7  index of the register written; valid with wr_stb
busy  out  1  high from an addressed START to the STOP

Behaviour:
- Reset values: sda_oe=0, all rw_regs=0, wr_stb=0, wr_idx=0, busy=0, pointer=0, FSM=IDLE. sda_oe is released asynchronously when rst_n asserts mid-transfer.
- Input path: each of SDA and SCL goes through a 2-FF synchroniser, then a FILT_LEN-deep majority/stable filter. All edge detection uses the filtered signals.
- Framing: START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. A START from any state (repeated start) goes to ADDR. A STOP from any state goes to IDLE, releases SDA and clears busy.
- Data timing: the target samples data on the filtered SCL rising edge. It changes sda_oe only on the SCL falling edge, at least 1 clk after the edge is detected, and never while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift in 8 bits. On a 7-bit match, drive ACK and set busy. R/W=0 goes to SUB. R/W=1 goes to RDATA and loads reg[pointer] on the ACK falling edge. On a mismatch, go to IGNORE with no ACK; IGNORE waits for START or STOP.
- SUB: if the byte is < NUM_REGS, ACK and set pointer=byte. Otherwise NAK, leave the pointer unchanged, and go to IGNORE.
- WDATA: after 8 bits, always ACK.
  - If pointer < RO_FIRST: write rw_regs[pointer] and pulse wr_stb with wr_idx=pointer, in the cycle after the 8th rising edge.
  - Writes to RO registers are acked but discarded, with no wr_stb.
  - The pointer then increments; NUM_REGS-1 wraps to 0.
- RDATA: shift the loaded byte out MSB-first. In RDATA_ACK, sample the master's ACK bit.
  - ACK (0): increment the pointer with wrap, load the next byte and continue.
  - NAK (1): release SDA and go to IGNORE until STOP/START.
- Read loading: the byte is loaded at the SCL falling edge that starts the byte. An RO byte reflects ro_in at that cycle, and the read shows an RW value as it is at that moment.
- Pointer persistence: the pointer persists across transactions. A read without a preceding subaddress continues from the last pointer.
- Simultaneous events: a START/STOP detected in the same cycle as an SCL edge takes priority. wr_stb is never issued for a byte interrupted by START/STOP.

Decomposition:
- Package i2c_pkg: FSM state enum, START/STOP/edge event type, ACK=1'b0 and NAK=1'b1 constants, and a clog2 helper for the pointer width.
- Sub-module i2c_pin_filter (sync + filter + rise/fall detect), instantiated twice, once for SDA and once for SCL. The FSM, shifter and register bank stay in i2c_target_regs.

Test Plan:
1. Reset, then write 0xE0, sub 0x00, data 0xAA, 0x55, STOP -> all four bytes acked; rw_regs[7:0]=0xAA, [15:8]=0x55; two wr_stb pulses with wr_idx=0, then 1.
2. Set ro_in bytes to 0xC0..0xC3. Write sub 0x00, repeated START, 0xE1, read 16 bytes acking all but the last -> data is regs 0..11 then 0xC0..0xC3; the last NAK releases SDA; busy falls at STOP.
3. Write sub 0x0A with data 0x11, 0x22, 0x33, 0x44 -> regs 10 and 11 are written; bytes for 12 and 13 are acked, give no wr_stb, and leave ro unchanged; the pointer ends at 14.
4. Write to sub 0x0F, then read 2 bytes -> wrap: reads return reg15 (RO) then reg0.
5. Address 0xE2, and separately sub 0x20 -> first is NAKed with no bus activity until STOP; second has address acked and sub NAKed, with registers unchanged.
6. Inject 1-clk SCL glitches with FILT_LEN=3, and assert rst_n low mid-read while SDA is driven -> the glitches cause no bit shift; reset releases sda_oe the same instant and clears rw_regs to 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register bank.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StSub,
        StSubAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } i2c_state_e;

    typedef enum logic [2:0] {
        EvNone,
        EvStart,
        EvStop,
        EvSclRise,
        EvSclFall
    } bus_ev_e;

    localparam logic ACK = 1'b0;
    localparam logic NAK = 1'b1;

    // Pointer width; never below one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/i2c_pin_filter.sv
// Pad input conditioning: 2-FF synchroniser, stable-count glitch filter, edge pulses.
module i2c_pin_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic [2:0] cnt_q, cnt_d;
    logic       filt_q, filt_d;
    logic       rise_q, fall_q;
    logic       flip;

    // Output follows the input only after it has differed for FILT_LEN consecutive cycles.
    always_comb begin
        cnt_d = '0;
        flip  = 1'b0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == 3'(FILT_LEN - 1)) flip = 1'b1;
            else cnt_d = cnt_q + 3'd1;
        end
        filt_d = flip ? sync_q[1] : filt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_in};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= flip & sync_q[1];
            fall_q <= flip & ~sync_q[1];
        end
    end

    assign filt = filt_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with NUM_REGS byte registers: RW bank below RO_FIRST, status bytes above.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR = 7'h70,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned RO_FIRST = 12,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sda_in,
    input  logic                             scl_in,
    output logic                             sda_oe,
    output logic [RO_FIRST*8-1:0]            rw_regs,
    input  logic [(NUM_REGS-RO_FIRST)*8-1:0] ro_in,
    output logic                             wr_stb,
    output logic [6:0]                       wr_idx,
    output logic                             busy
);

    localparam int unsigned PtrW = clog2(NUM_REGS);

    logic sda_f, sda_rise, sda_fall, scl_f, scl_rise, scl_fall;

    i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .pin_in(sda_in),
        .filt  (sda_f),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .pin_in(scl_in),
        .filt  (scl_f),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_state_e      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [PtrW-1:0] ptr_q, ptr_d, ptr_inc;
    logic            sda_oe_q, sda_oe_d;
    logic            ack_ph_q, ack_ph_d;
    logic            busy_q, busy_d;
    logic            wr_stb_q, wr_stb_d;
    logic [6:0]      wr_idx_q, wr_idx_d;
    logic [7:0]      rw_q [RO_FIRST];
    logic [7:0]      rw_d [RO_FIRST];
    logic [7:0]      rd_bytes [NUM_REGS];
    logic [7:0]      rx_byte, load_byte;
    bus_ev_e         ev;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_rd
        if (k < RO_FIRST) begin : g_rw
            assign rd_bytes[k]       = rw_q[k];
            assign rw_regs[8*k +: 8] = rw_q[k];
        end else begin : g_ro
            assign rd_bytes[k] = ro_in[8*(k-RO_FIRST) +: 8];
        end
    end

    assign ptr_inc   = (32'(ptr_q) == NUM_REGS - 1) ? '0 : ptr_q + 1'b1;
    assign rx_byte   = {shift_q[6:0], sda_f};
    assign load_byte = rd_bytes[ptr_q];

    // Bus framing outranks clock edges seen in the same cycle.
    always_comb begin
        ev = EvNone;
        if (scl_f && sda_fall)      ev = EvStart;
        else if (scl_f && sda_rise) ev = EvStop;
        else if (scl_rise)          ev = EvSclRise;
        else if (scl_fall)          ev = EvSclFall;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        ack_ph_d  = ack_ph_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_idx_d  = wr_idx_q;
        rw_d      = rw_q;
        unique case (ev)
            EvNone: ;
            EvStart: begin
                state_d   = StAddr;
                bit_cnt_d = '0;
                sda_oe_d  = 1'b0;
                ack_ph_d  = 1'b0;
            end
            EvStop: begin
                state_d  = StIdle;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
            EvSclRise: begin
                case (state_q)
                    StAddr, StSub, StWdata: begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_ph_d = 1'b0;
                            if (state_q == StAddr) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    busy_d  = 1'b1;
                                    state_d = StAddrAck;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else if (state_q == StSub) begin
                                if (32'(rx_byte) < NUM_REGS) begin
                                    ptr_d   = rx_byte[PtrW-1:0];
                                    state_d = StSubAck;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else begin
                                if (32'(ptr_q) < RO_FIRST) begin
                                    for (int k = 0; k < int'(RO_FIRST); k++) begin
                                        if (32'(ptr_q) == 32'(k)) rw_d[k] = rx_byte;
                                    end
                                    wr_stb_d = 1'b1;
                                    wr_idx_d = 7'(ptr_q);
                                end
                                ptr_d   = ptr_inc;
                                state_d = StWdataAck;
                            end
                        end
                    end
                    StRdata: begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d  = StRdataAck;
                            ack_ph_d = 1'b0;
                        end
                    end
                    StRdataAck: begin
                        if (ack_ph_q) begin
                            if (sda_f == NAK) begin
                                state_d  = StIgnore;
                                sda_oe_d = 1'b0;
                            end else begin
                                ptr_d = ptr_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            EvSclFall: begin
                // Ack states: first fall opens the ack bit, second fall closes it.
                case (state_q)
                    StAddrAck, StSubAck, StWdataAck: begin
                        if (!ack_ph_q) begin
                            sda_oe_d = ~ACK;
                            ack_ph_d = 1'b1;
                        end else begin
                            ack_ph_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == StAddrAck && shift_q[0]) begin
                                shift_d  = load_byte;
                                sda_oe_d = ~load_byte[7];
                                state_d  = StRdata;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = (state_q == StAddrAck) ? StSub : StWdata;
                            end
                        end
                    end
                    StRdata: begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                    StRdataAck: begin
                        if (!ack_ph_q) begin
                            sda_oe_d = 1'b0;
                            ack_ph_d = 1'b1;
                        end else begin
                            shift_d   = load_byte;
                            sda_oe_d  = ~load_byte[7];
                            bit_cnt_d = '0;
                            ack_ph_d  = 1'b0;
                            state_d   = StRdata;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            ack_ph_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= '0;
            for (int k = 0; k < int'(RO_FIRST); k++) rw_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            ack_ph_q  <= ack_ph_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_idx_q  <= wr_idx_d;
            rw_q      <= rw_d;
        end
    end

    assign sda_oe = sda_oe_q;
    assign busy   = busy_q;
    assign wr_stb = wr_stb_q;
    assign wr_idx = wr_idx_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench for i2c_target_regs with an open-drain master and a register model.
module tb_i2c_target_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sda_m, scl_m;
    logic        sda_bus;
    logic        sda_oe;
    logic [95:0] rw_regs;
    logic [31:0] ro_in;
    logic        wr_stb;
    logic [6:0]  wr_idx;
    logic        busy;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regs #(
        .I2C_ADDR(7'h70),
        .NUM_REGS(16),
        .RO_FIRST(12),
        .FILT_LEN(3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sda_in (sda_bus),
        .scl_in (scl_m),
        .sda_oe (sda_oe),
        .rw_regs(rw_regs),
        .ro_in  (ro_in),
        .wr_stb (wr_stb),
        .wr_idx (wr_idx),
        .busy   (busy)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_regs [16];
    int         m_ptr;
    int         exp_stb[$];
    int         stb_q[$];
    logic [7:0] wq[$];
    bit         glitch_en;
    bit         saw_oe;

    always @(negedge clk) begin
        if (rst_n && wr_stb) stb_q.push_back(int'(wr_idx));
        if (sda_oe) saw_oe = 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_byte(input int idx);
        return (idx < 12) ? m_regs[idx] : ro_in[8*(idx-12) +: 8];
    endfunction

    function automatic logic [95:0] m_pack();
        logic [95:0] v;
        for (int k = 0; k < 12; k++) v[8*k +: 8] = m_regs[k];
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (glitch_en) begin
            wait_clk(3); sda_m = b; scl_m = 1'b1; wait_clk(1); scl_m = 1'b0; wait_clk(4);
        end else begin
            wait_clk(8); sda_m = b;
        end
        wait_clk(8);
        scl_m = 1'b1;
        if (glitch_en && b) begin
            wait_clk(4); sda_m = 1'b0; wait_clk(1); sda_m = 1'b1; wait_clk(11);
        end else begin
            wait_clk(16);
        end
        scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(8); sda_m = 1'b1;
        wait_clk(8); scl_m = 1'b1;
        wait_clk(8); b = sda_bus;
        wait_clk(8); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            wait_clk(8); sda_m = 1'b1;
            wait_clk(8); scl_m = 1'b1;
            wait_clk(8);
        end
        sda_m = 1'b0;
        wait_clk(8);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(8); sda_m = 1'b0;
        wait_clk(8); scl_m = 1'b1;
        wait_clk(8); sda_m = 1'b1;
        wait_clk(16);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nak, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nak);
    endtask

    task automatic chk_stb();
        chk("wr_stb count", 128'(stb_q.size()), 128'(exp_stb.size()));
        for (int i = 0; i < stb_q.size() && i < exp_stb.size(); i++)
            chk($sformatf("wr_idx #%0d", i), 128'(stb_q[i]), 128'(exp_stb[i]));
        stb_q.delete();
        exp_stb.delete();
    endtask

    task automatic wr_txn(input logic [7:0] sub);
        logic a;
        i2c_start();
        write_byte(8'hE0, a);
        chk("wr addr ack", a, 0);
        chk("busy after addr", busy, 1);
        write_byte(sub, a);
        chk("wr sub ack", a, 0);
        m_ptr = int'(sub);
        foreach (wq[i]) begin
            write_byte(wq[i], a);
            chk($sformatf("wr data ack %0d", i), a, 0);
            if (m_ptr < 12) begin
                m_regs[m_ptr] = wq[i];
                exp_stb.push_back(m_ptr);
            end
            m_ptr = (m_ptr + 1) % 16;
        end
        i2c_stop();
        chk("busy after wr stop", busy, 0);
        chk("rw_regs", rw_regs, m_pack());
        chk_stb();
    endtask

    task automatic rd_txn(input bit with_sub, input logic [7:0] sub, input int n);
        logic       a;
        logic [7:0] d, e;
        i2c_start();
        if (with_sub) begin
            write_byte(8'hE0, a);
            chk("rd wr-addr ack", a, 0);
            write_byte(sub, a);
            chk("rd sub ack", a, 0);
            m_ptr = int'(sub);
            i2c_start();
        end
        write_byte(8'hE1, a);
        chk("rd addr ack", a, 0);
        for (int i = 0; i < n; i++) begin
            e = m_byte(m_ptr);
            read_byte(i == n - 1, d);
            chk($sformatf("rd data %0d", i), d, e);
            if (i != n - 1) m_ptr = (m_ptr + 1) % 16;
        end
        wait_clk(10);
        chk("sda released after nak", sda_oe, 0);
        chk("busy before rd stop", busy, 1);
        i2c_stop();
        chk("busy after rd stop", busy, 0);
    endtask

    initial begin
        logic       a, b;
        bit         found;
        rst_n = 1'b0;
        sda_m = 1'b1;
        scl_m = 1'b1;
        glitch_en = 1'b0;
        saw_oe = 1'b0;
        ro_in = $urandom;
        m_reset();
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        chk("rst sda_oe", sda_oe, 0);
        chk("rst rw_regs", rw_regs, 0);
        chk("rst wr_stb", wr_stb, 0);
        chk("rst wr_idx", wr_idx, 0);
        chk("rst busy", busy, 0);

        // Basic two-byte write.
        wq = '{8'hAA, 8'h55};
        wr_txn(8'h00);
        chk("reg0 value", rw_regs[7:0], 8'hAA);
        chk("reg1 value", rw_regs[15:8], 8'h55);

        // Fill the rest of the RW bank, then read the whole map.
        ro_in = 32'hC3C2C1C0;
        wq.delete();
        for (int i = 0; i < 10; i++) wq.push_back(8'($urandom));
        wr_txn(8'h02);
        rd_txn(1'b1, 8'h00, 16);

        // Write across the RW/RO boundary, then continue reading from the pointer.
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_txn(8'h0A);
        rd_txn(1'b0, 8'h00, 2);

        // Pointer wrap from the last register.
        ro_in = $urandom;
        wq.delete();
        wr_txn(8'h0F);
        rd_txn(1'b0, 8'h00, 2);

        // Foreign address: no response at all.
        saw_oe = 1'b0;
        i2c_start();
        write_byte(8'hE2, a);
        chk("foreign addr nak", a, 1);
        write_byte(8'($urandom), a);
        chk("foreign data nak", a, 1);
        chk("foreign busy", busy, 0);
        i2c_stop();
        chk("foreign sda quiet", saw_oe, 0);

        // Out-of-range subaddress.
        i2c_start();
        write_byte(8'hE0, a);
        chk("bad-sub addr ack", a, 0);
        write_byte(8'h20, a);
        chk("bad-sub nak", a, 1);
        write_byte(8'($urandom), a);
        chk("bad-sub data nak", a, 1);
        i2c_stop();
        chk("bad-sub rw_regs", rw_regs, m_pack());
        chk_stb();
        rd_txn(1'b0, 8'h00, 1);

        // Glitches on SCL (low phase) and SDA (high phase) must be filtered.
        glitch_en = 1'b1;
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(8'($urandom));
        wr_txn(8'h05);
        glitch_en = 1'b0;

        // Reset while the target is pulling SDA low during a read.
        ro_in = 32'hC3C2C1C0;
        i2c_start();
        write_byte(8'hE0, a);
        write_byte(8'h0C, a);
        i2c_start();
        write_byte(8'hE1, a);
        chk("mid-read addr ack", a, 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            recv_bit(b);
            wait_clk(10);
            if (sda_oe) found = 1'b1;
        end
        chk("target drove low bit", found, 1);
        rst_n = 1'b0;
        #1;
        chk("async sda release", sda_oe, 0);
        chk("reset clears rw_regs", rw_regs, 0);
        chk("reset clears busy", busy, 0);
        wait_clk(4);
        rst_n = 1'b1;
        m_reset();
        i2c_stop();
        rd_txn(1'b0, 8'h00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
